vram_fill_arbiter: RTL and testbench

VRAM_FILL_ARBITER -- requirements
Module: vram_fill_arbiter

---
 rtl/vram_fill_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_vram_fill_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fill_arbiter.sv
// vram_fill_arbiter
//   Shares a single VRAM write port between a CPU and a hardware
//   rectangle-less linear fill engine. The CPU always has priority; the fill
//   engine writes one word per cycle whenever the CPU is not granted.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   cpu_req/we/addr/data     CPU access strobe (level), direction, address, data
//   cpu_dtack_n              active-low acknowledge, low while the access is held
//   reg_wr/reg_sel/reg_data  fill register write port
//                              0: start address[15:0]
//                              1: length in words
//                              2: colour[11:0]
//                              3: control (bit0 go, bit1 abort, bit2 start address[16])
//   vram_we/addr/data        registered VRAM write port
//   busy                     fill engine running
//   done                     sticky fill-complete flag, cleared by any control write
//   irq                      completion interrupt
//
// Build option
//   VRAM_FILL_IRQ_EN  when defined, irq rises with done and clears on a control
//                     write; when undefined, irq is tied low.

module vram_fill_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [16:0] cpu_addr,
  input  logic [15:0] cpu_data,
  output logic        cpu_dtack_n,
  input  logic        reg_wr,
  input  logic [1:0]  reg_sel,
  input  logic [15:0] reg_data,
  output logic        vram_we,
  output logic [16:0] vram_addr,
  output logic [15:0] vram_data,
  output logic        busy,
  output logic        done,
  output logic        irq
);

  typedef enum logic {S_IDLE, S_FILL} fill_state_t;
  typedef enum logic {C_IDLE, C_ACK} cpu_state_t;

  fill_state_t state_q, state_d;
  cpu_state_t  cpu_state_q, cpu_state_d;

  // Programmable registers (start address bit 16 arrives with the go write)
  logic [15:0] start_lo_q, start_lo_d;
  logic [15:0] len_q, len_d;
  logic [11:0] colour_q, colour_d;

  // Working copies owned by the running fill
  logic [16:0] work_addr_q, work_addr_d;
  logic [15:0] remain_q, remain_d;
  logic [11:0] work_colour_q, work_colour_d;

  logic        vram_we_q, vram_we_d;
  logic [16:0] vram_addr_q, vram_addr_d;
  logic [15:0] vram_data_q, vram_data_d;
  logic        done_q, done_d;

  logic ctrl_wr, go, abort, grant, done_set;

  assign ctrl_wr = reg_wr && (reg_sel == 2'd3);
  // Abort wins when both go and abort are set.
  assign go      = ctrl_wr && reg_data[0] && !reg_data[1];
  assign abort   = ctrl_wr && reg_data[1];
  assign grant   = (cpu_state_q == C_IDLE) && cpu_req;

  always_comb begin
    state_d       = state_q;
    cpu_state_d   = cpu_state_q;
    start_lo_d    = start_lo_q;
    len_d         = len_q;
    colour_d      = colour_q;
    work_addr_d   = work_addr_q;
    remain_d      = remain_q;
    work_colour_d = work_colour_q;
    vram_we_d     = 1'b0;
    vram_addr_d   = vram_addr_q;
    vram_data_d   = vram_data_q;
    done_set      = 1'b0;

    if (reg_wr) begin
      unique case (reg_sel)
        2'd0:    start_lo_d = reg_data;
        2'd1:    len_d      = reg_data;
        2'd2:    colour_d   = reg_data[11:0];
        default: ;
      endcase
    end

    // CPU side: one access per request, acknowledge held until the strobe drops
    unique case (cpu_state_q)
      C_IDLE: begin
        if (cpu_req) begin
          cpu_state_d = C_ACK;
          vram_we_d   = cpu_we;
          vram_addr_d = cpu_addr;
          vram_data_d = cpu_data;
        end
      end
      C_ACK: begin
        if (!cpu_req) cpu_state_d = C_IDLE;
      end
      default: cpu_state_d = C_IDLE;
    endcase

    // Fill side
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          if (len_q != 16'd0) begin
            work_addr_d   = {reg_data[2], start_lo_q};
            remain_d      = len_q;
            work_colour_d = colour_q;
            state_d       = S_FILL;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!grant) begin
          vram_we_d   = 1'b1;
          vram_addr_d = work_addr_q;
          vram_data_d = {4'b0000, work_colour_q};
          work_addr_d = work_addr_q + 17'd1;
          remain_d    = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_d  = S_IDLE;
            done_set = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A control write clears done, but a completion on the same edge wins.
    done_d = ctrl_wr ? 1'b0 : done_q;
    if (done_set) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cpu_state_q   <= C_IDLE;
      start_lo_q    <= '0;
      len_q         <= '0;
      colour_q      <= '0;
      work_addr_q   <= '0;
      remain_q      <= '0;
      work_colour_q <= '0;
      vram_we_q     <= 1'b0;
      vram_addr_q   <= '0;
      vram_data_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_state_q   <= cpu_state_d;
      start_lo_q    <= start_lo_d;
      len_q         <= len_d;
      colour_q      <= colour_d;
      work_addr_q   <= work_addr_d;
      remain_q      <= remain_d;
      work_colour_q <= work_colour_d;
      vram_we_q     <= vram_we_d;
      vram_addr_q   <= vram_addr_d;
      vram_data_q   <= vram_data_d;
      done_q        <= done_d;
    end
  end

`ifdef VRAM_FILL_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = ctrl_wr ? 1'b0 : irq_q;
    if (done_set) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign cpu_dtack_n = (cpu_state_q != C_ACK);
  assign busy        = (state_q == S_FILL);
  assign done        = done_q;
  assign vram_we     = vram_we_q;
  assign vram_addr   = vram_addr_q;
  assign vram_data   = vram_data_q;

endmodule

// File: tb/tb_vram_fill_arbiter.sv
module tb_vram_fill_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [16:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_dtack_n;
  logic        reg_wr;
  logic [1:0]  reg_sel;
  logic [15:0] reg_data;
  logic        vram_we;
  logic [16:0] vram_addr;
  logic [15:0] vram_data;
  logic        busy, done, irq;

  int checks = 0;
  int errors = 0;

`ifdef VRAM_FILL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  // Every VRAM write seen on the port, as {addr, data}
  logic [32:0] wq[$];

  vram_fill_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_dtack_n (cpu_dtack_n),
    .reg_wr      (reg_wr),
    .reg_sel     (reg_sel),
    .reg_data    (reg_data),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_data   (vram_data),
    .busy        (busy),
    .done        (done),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && vram_we) wq.push_back({vram_addr, vram_data});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] sel, input logic [15:0] data);
    reg_wr   = 1'b1;
    reg_sel  = sel;
    reg_data = data;
    tick();
    reg_wr   = 1'b0;
  endtask

  task automatic start_fill(input logic [16:0] a, input logic [15:0] l, input logic [11:0] c);
    reg_write(2'd0, a[15:0]);
    reg_write(2'd1, l);
    reg_write(2'd2, {4'h0, c});
    wq.delete();
    reg_write(2'd3, {13'd0, a[16], 2'b01});
  endtask

  task automatic compare_q(input string tag, input logic [32:0] got[$], input logic [32:0] exp[$]);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  // Reference: a linear fill of l words from a, wrapping at 17 bits
  function automatic void fill_model(input logic [16:0] a, input int l, input logic [11:0] c,
                                     output logic [32:0] q[$]);
    logic [16:0] ad;
    q.delete();
    for (int i = 0; i < l; i++) begin
      ad = 17'((int'(a) + i) % 131072);
      q.push_back({ad, 4'h0, c});
    end
  endfunction

  initial begin
    logic [32:0] exp_q[$], got_fill[$], got_cpu[$], exp_cpu[$], tmp[$];
    logic [16:0] ra;
    logic [15:0] rl;
    logic [11:0] rc;
    int n, g;

    reset_n  = 1'b0;
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;
    reg_wr   = 1'b0;
    reg_sel  = '0;
    reg_data = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_irq", irq, 0);
    chk("rst_dtack", cpu_dtack_n, 1);
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_data", vram_data, 0);
    reset_n = 1'b1;
    tick();

    // Basic fill of 4 words
    start_fill(17'h00100, 16'd4, 12'hABC);
    chk("f4_done_clr", done, 0);
    n = 0;
    while (busy && n < 50) begin n++; tick(); end
    chk("f4_busy_cycles", n, 4);
    chk("f4_done", done, 1);
    chk("f4_irq", irq, IRQ_ON);
    tick(); tick();
    fill_model(17'h00100, 4, 12'hABC, exp_q);
    compare_q("f4_wr", wq, exp_q);

    // Address wrap
    start_fill(17'h1FFFE, 16'd3, 12'h321);
    n = 0;
    while (busy && n < 50) begin n++; tick(); end
    chk("wrap_busy_cycles", n, 3);
    chk("wrap_done", done, 1);
    tick(); tick();
    fill_model(17'h1FFFE, 3, 12'h321, exp_q);
    compare_q("wrap_wr", wq, exp_q);

    // Zero length: no writes, done next cycle
    reg_write(2'd3, 16'h0000);
    chk("z_done_clr", done, 0);
    chk("z_irq_clr", irq, 0);
    reg_write(2'd1, 16'd0);
    wq.delete();
    reg_write(2'd3, 16'h0001);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_irq", irq, IRQ_ON);
    tick(); tick(); tick();
    chk("z_writes", wq.size(), 0);
    reg_write(2'd3, 16'h0000);
    chk("z_done_ctrl", done, 0);
    chk("z_irq_ctrl", irq, 0);

    // go together with abort behaves as abort: nothing starts
    reg_write(2'd1, 16'd5);
    wq.delete();
    reg_write(2'd3, 16'h0003);
    chk("ga_busy", busy, 0);
    tick(); tick(); tick();
    chk("ga_writes", wq.size(), 0);

    // CPU write in the middle of an 8-word fill, request held three cycles
    start_fill(17'h00200, 16'd8, 12'h123);
    tick(); tick(); tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00050; cpu_data = 16'h0F0F;
    tick();
    chk("cpu_dtack_e4", cpu_dtack_n, 0);
    chk("cpu_we", vram_we, 1);
    chk("cpu_addr", vram_addr, 17'h00050);
    chk("cpu_data", vram_data, 16'h0F0F);
    tick();
    chk("cpu_dtack_e5", cpu_dtack_n, 0);
    tick();
    chk("cpu_dtack_e6", cpu_dtack_n, 0);
    cpu_req = 1'b0;
    tick();
    chk("cpu_dtack_e7", cpu_dtack_n, 1);
    n = 0;
    while (busy && n < 50) begin n++; tick(); end
    chk("cpu_fill_edges", 7 + n, 9);
    chk("cpu_done", done, 1);
    tick(); tick();
    fill_model(17'h00200, 8, 12'h123, tmp);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(tmp[i]);
    exp_q.push_back({17'h00050, 16'h0F0F});
    for (int i = 3; i < 8; i++) exp_q.push_back(tmp[i]);
    compare_q("cpu_seq", wq, exp_q);

    // Abort after two writes of a 10-word fill
    start_fill(17'h00300, 16'd10, 12'h555);
    tick(); tick();
    reg_write(2'd3, 16'h0002);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    tick(); tick(); tick(); tick();
    fill_model(17'h00300, 2, 12'h555, exp_q);
    compare_q("ab_wr", wq, exp_q);

    // Reset in the middle of a fill
    start_fill(17'h00400, 16'd10, 12'h777);
    tick(); tick();
    #2;
    reset_n = 1'b0;
    wq.delete();
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_irq", irq, 0);
    chk("mr_dtack", cpu_dtack_n, 1);
    chk("mr_we", vram_we, 0);
    chk("mr_addr", vram_addr, 0);
    chk("mr_data", vram_data, 0);
    #3;
    reset_n = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("mr_writes", wq.size(), 0);
    chk("mr_busy_after", busy, 0);

    // Randomised fills with random CPU traffic and register writes during the fill
    for (int it = 0; it < 20; it++) begin
      ra = ($urandom_range(0, 1) == 1) ? 17'(17'h1FFF0 + 17'($urandom_range(0, 15)))
                                       : 17'($urandom);
      rl = 16'($urandom_range(1, 24));
      rc = 12'($urandom);
      exp_cpu.delete();
      start_fill(ra, rl, rc);
      g = 0;
      while (busy && g < 300) begin
        g++;
        if (cpu_req && !cpu_dtack_n) begin
          cpu_req = 1'b0;
        end else if (!cpu_req && cpu_dtack_n && $urandom_range(0, 3) == 0) begin
          cpu_req  = 1'b1;
          cpu_we   = 1'($urandom);
          cpu_addr = 17'($urandom);
          cpu_data = {4'hF, 12'($urandom)};
          if (cpu_we) exp_cpu.push_back({cpu_addr, cpu_data});
        end
        reg_wr   = ($urandom_range(0, 4) == 0);
        reg_sel  = 2'($urandom_range(0, 2));
        reg_data = 16'($urandom);
        tick();
        reg_wr = 1'b0;
      end
      cpu_req = 1'b0;
      n = 0;
      while (!cpu_dtack_n && n < 10) begin n++; tick(); end
      tick(); tick();
      chk($sformatf("rnd%0d_done", it), done, 1);
      got_fill.delete();
      got_cpu.delete();
      foreach (wq[i]) begin
        if (wq[i][15:12] == 4'hF) got_cpu.push_back(wq[i]);
        else                      got_fill.push_back(wq[i]);
      end
      fill_model(ra, int'(rl), rc, exp_q);
      compare_q($sformatf("rnd%0d_fill", it), got_fill, exp_q);
      compare_q($sformatf("rnd%0d_cpu", it), got_cpu, exp_cpu);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
